// File: rtl/csa_stage_skid.sv
// Carry-save pipeline stage for the Wallace-tree FP multiplier: a 2-entry skid buffer
// (main + skid) for {d1, d2, side}, with sync flush. Optional stall counter: CSA_STALL_CNT_EN.

module csa_stage_skid_slice #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_main,
  input  logic         main_from_skid,
  input  logic         ld_skid,
  input  logic [W-1:0] in_d,
  output logic [W-1:0] main_d
);
  logic [W-1:0] skid_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_d <= '0;
      skid_d <= '0;
    end else begin
      if (ld_main) main_d <= main_from_skid ? skid_d : in_d;
      if (ld_skid) skid_d <= in_d;
    end
  end
endmodule

module csa_stage_skid #(
  parameter int ROWS   = 10,
  parameter int ROW_W  = 65,
  parameter int SIDE_W = 74,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*ROW_W-1:0] in_d1,
  input  logic [ROWS*ROW_W-1:0] in_d2,
  input  logic [SIDE_W-1:0]     in_side,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROWS*ROW_W-1:0] out_d1,
  output logic [ROWS*ROW_W-1:0] out_d2,
  output logic [SIDE_W-1:0]     out_side
`ifdef CSA_STALL_CNT_EN
  ,output logic [CNT_W-1:0]     stall_cnt
`endif
);
  logic main_v, skid_v, main_v_n, skid_v_n;
  logic ld_main, main_from_skid, ld_skid;
  logic in_xfer, out_xfer;

  assign out_valid = main_v;
  assign in_xfer   = in_valid & in_ready & ~flush;
  assign out_xfer  = main_v & out_ready;

  // Skid only fills while main is full and stalled; in_ready drops the cycle after,
  // so main draining with skid full never coincides with a new accept.
  always_comb begin
    main_v_n       = main_v;
    skid_v_n       = skid_v;
    ld_main        = 1'b0;
    main_from_skid = 1'b0;
    ld_skid        = 1'b0;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (!main_v) begin
      if (in_xfer) begin
        ld_main  = 1'b1;
        main_v_n = 1'b1;
      end
    end else if (out_xfer) begin
      if (skid_v) begin
        ld_main        = 1'b1;
        main_from_skid = 1'b1;
        skid_v_n       = 1'b0;
      end else if (in_xfer) begin
        ld_main = 1'b1;
      end else begin
        main_v_n = 1'b0;
      end
    end else if (in_xfer) begin
      ld_skid  = 1'b1;
      skid_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      main_v   <= main_v_n;
      skid_v   <= skid_v_n;
      in_ready <= ~skid_v_n;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    csa_stage_skid_slice #(.W(ROW_W)) u_d1 (
      .clk(clk), .rst(rst), .ld_main(ld_main), .main_from_skid(main_from_skid),
      .ld_skid(ld_skid), .in_d(in_d1[r*ROW_W +: ROW_W]), .main_d(out_d1[r*ROW_W +: ROW_W])
    );
    csa_stage_skid_slice #(.W(ROW_W)) u_d2 (
      .clk(clk), .rst(rst), .ld_main(ld_main), .main_from_skid(main_from_skid),
      .ld_skid(ld_skid), .in_d(in_d2[r*ROW_W +: ROW_W]), .main_d(out_d2[r*ROW_W +: ROW_W])
    );
  end

  csa_stage_skid_slice #(.W(SIDE_W)) u_side (
    .clk(clk), .rst(rst), .ld_main(ld_main), .main_from_skid(main_from_skid),
    .ld_skid(ld_skid), .in_d(in_side), .main_d(out_side)
  );

`ifdef CSA_STALL_CNT_EN
  // Saturating count of cycles a valid beat sits unaccepted; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (main_v && !out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_csa_stage_skid.sv
// Directed bench for csa_stage_skid: reset, streaming, backpressure, flush, mid-stream reset,
// and the stall counter when CSA_STALL_CNT_EN is defined.
module tb_csa_stage_skid;
  localparam int ROWS   = 10;
  localparam int ROW_W  = 65;
  localparam int SIDE_W = 74;
  localparam int CNT_W  = 4;
  localparam int DW     = ROWS * ROW_W;

  logic              clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]     in_d1, in_d2, out_d1, out_d2;
  logic [SIDE_W-1:0] in_side, out_side;
`ifdef CSA_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  csa_stage_skid #(.ROWS(ROWS), .ROW_W(ROW_W), .SIDE_W(SIDE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_d1(in_d1), .in_d2(in_d2), .in_side(in_side), .out_valid(out_valid),
    .out_ready(out_ready), .out_d1(out_d1), .out_d2(out_d2), .out_side(out_side)
`ifdef CSA_STALL_CNT_EN
    ,.stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_d1(int t);
    logic [DW-1:0] v;
    v = '0;
    v[0 +: ROW_W] = ROW_W'(t * 3);
    v[(ROWS-1)*ROW_W +: ROW_W] = ~ROW_W'(t);
    return v;
  endfunction

  function automatic logic [DW-1:0] mk_d2(int t);
    logic [DW-1:0] v;
    v = ~mk_d1(t);
    v[ROW_W +: ROW_W] = ROW_W'(t) << 7;
    return v;
  endfunction

  function automatic logic [SIDE_W-1:0] mk_side(int t);
    logic [SIDE_W-1:0] v;
    v = '0;
    v[31:0]  = 32'(t);
    v[63:32] = 32'(t + 1000);
    v[72:64] = 9'(t);
    v[73]    = t[0];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(int t);
    in_valid = 1'b1;
    in_d1    = mk_d1(t);
    in_d2    = mk_d2(t);
    in_side  = mk_side(t);
  endtask

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(string tag, int t);
    chk({tag, ".valid"}, DW'(out_valid), DW'(1));
    chk({tag, ".d1"}, out_d1, mk_d1(t));
    chk({tag, ".d2"}, out_d2, mk_d2(t));
    chk({tag, ".side"}, DW'(out_side), DW'(mk_side(t)));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_d1 = '0; in_d2 = '0; in_side = '0;
    step(); step();
    chk("rst.in_ready", DW'(in_ready), DW'(0));
    chk("rst.out_valid", DW'(out_valid), DW'(0));
    chk("rst.d1", out_d1, '0);
    chk("rst.d2", out_d2, '0);
    chk("rst.side", DW'(out_side), '0);
    rst = 1'b1;
    chk("rel.in_ready0", DW'(in_ready), DW'(0));
    step();
    chk("rel.in_ready1", DW'(in_ready), DW'(1));
    chk("rel.out_valid", DW'(out_valid), DW'(0));

    // streaming at one beat per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      present(i);
      step();
      chk_beat($sformatf("stream%0d", i), i);
      chk($sformatf("stream%0d.in_ready", i), DW'(in_ready), DW'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream.drain", DW'(out_valid), DW'(0));

    // backpressure: A main, B skid, C held upstream
    out_ready = 1'b0;
    present(20); step();
    chk_beat("bp.A", 20);
    chk("bp.rdyA", DW'(in_ready), DW'(1));
    present(21); step();
    chk_beat("bp.A_hold", 20);
    chk("bp.rdyB", DW'(in_ready), DW'(0));
    present(22); step();
    chk_beat("bp.A_hold2", 20);
    chk("bp.rdyC", DW'(in_ready), DW'(0));
    out_ready = 1'b1; step();
    chk_beat("bp.B", 21);
    chk("bp.rdy_after", DW'(in_ready), DW'(1));
    step();
    chk_beat("bp.C", 22);
    in_valid = 1'b0; step();
    chk("bp.drain", DW'(out_valid), DW'(0));

    // flush with main and skid full while C is presented
    out_ready = 1'b0;
    present(30); step();
    present(31); step();
    chk("fl.rdy_full", DW'(in_ready), DW'(0));
    present(32); flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.out_valid", DW'(out_valid), DW'(0));
    chk("fl.in_ready", DW'(in_ready), DW'(1));
    out_ready = 1'b1; step();
    chk("fl.empty", DW'(out_valid), DW'(0));
    present(33); step();
    chk_beat("fl.D", 33);
    in_valid = 1'b0; step();
    chk("fl.drain", DW'(out_valid), DW'(0));

    // reset with both entries full
    out_ready = 1'b0;
    present(40); step();
    present(41); step();
    chk("mr.full", DW'(in_ready), DW'(0));
    rst = 1'b0; in_valid = 1'b0; step();
    chk("mr.out_valid", DW'(out_valid), DW'(0));
    chk("mr.in_ready", DW'(in_ready), DW'(0));
    chk("mr.d1", out_d1, '0);
    chk("mr.d2", out_d2, '0);
    chk("mr.side", DW'(out_side), '0);
    rst = 1'b1; step();
    chk("mr.rdy", DW'(in_ready), DW'(1));
    out_ready = 1'b1; step();
    chk("mr.no_skid", DW'(out_valid), DW'(0));

`ifdef CSA_STALL_CNT_EN
    chk("sc.zero", DW'(stall_cnt), DW'(0));
    out_ready = 1'b0;
    present(50); step();
    in_valid = 1'b0;
    chk("sc.zero_load", DW'(stall_cnt), DW'(0));
    step();
    chk("sc.one", DW'(stall_cnt), DW'(1));
    for (int i = 0; i < 19; i++) step();
    chk("sc.sat", DW'(stall_cnt), DW'(15));
    flush = 1'b1; step(); flush = 1'b0;
    chk("sc.flush", DW'(stall_cnt), DW'(15));
    rst = 1'b0; step(); rst = 1'b1;
    chk("sc.rst", DW'(stall_cnt), DW'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/csa_stage_skid.md
Name: csa_stage_skid

Overview:
- Parametrised pipeline stage register for the Wallace-tree FP multiplier.
- Carries two carry-save row vectors (d1 and d2) plus a sideband word:
  - sideband[31:0] = mantissa A
  - sideband[63:32] = mantissa B
  - sideband[72:64] = exponent
  - sideband[73] = sign
- Successor to the fixed per-level stage registers. One module is instantiated per reduction level with ROWS set per level.
- Adds valid/ready backpressure through a 2-entry skid buffer, plus a synchronous flush.

Parameters:
- ROWS, 10, rows per vector (1..32).
- ROW_W, 65, bits per row.
- SIDE_W, 74, sideband width.
- CNT_W, 16, width of the stall counter (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  discard all held beats and the beat presented this cycle.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept (registered).
- in_d1  in  ROWS*ROW_W  vector 1; row r = bits [r*ROW_W +: ROW_W].
- in_d2  in  ROWS*ROW_W  vector 2, same packing.
- in_side  in  SIDE_W  sideband.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_d1  out  ROWS*ROW_W  registered vector 1.
- out_d2  out  ROWS*ROW_W  registered vector 2.
- out_side  out  SIDE_W  registered sideband.
- stall_cnt  out  CNT_W  present only with CSA_STALL_CNT_EN.

Behaviour:
- Reset (rst=0 at clk edge):
  - main/skid valid=0, all data registers=0, in_ready=0, stall_cnt=0.
  - out_valid=0; out_d1, out_d2, out_side all 0.
- State per entry: main (drives outputs) and skid (overflow). Both are {valid, d1, d2, side}.
- Transfer definitions:
  - in_xfer = in_valid & in_ready & ~flush.
  - out_xfer = out_valid & out_ready.
- Next-state rules, no flush:
  - main empty: in_xfer loads main.
  - main full, out_xfer: main <= skid if skid valid; else main <= incoming if in_xfer; else main empties.
  - main full, out_xfer, skid valid, in_xfer: not reachable, because in_ready=0 while skid valid.
  - main full, no out_xfer, in_xfer: incoming goes to skid.
  - Skid is written only when main is full and not draining.
- in_ready is registered: in_ready <= ~skid_valid_next.
  - in_ready is 0 in the first cycle after rst rises, then 1.
- Latency and throughput:
  - Latency is 1 cycle from in_xfer into an empty stage to out_valid=1.
  - Sustained throughput is 1 beat/cycle with out_ready held high.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by flush.
- Data registers load only on a write. Payload is not cleared when an entry empties, but out_valid=0 then.
- Flush:
  - Next cycle: main_valid=0, skid_valid=0, in_ready=1.
  - The beat presented in the flush cycle is discarded.
  - An out_xfer in the flush cycle still counts as delivered.
- Reset mid-operation: all held beats are lost; state is as in reset.
- Width rule: pure storage, no arithmetic on payload; bit-exact passthrough.

Optional Feature:
- Macro: CSA_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset only; flush does not clear it.
- Undefined: stall_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then rst=1 -> in_ready=0 for 1 cycle then 1; out_valid=0; out_d1/out_d2/out_side=0.
- Streaming, out_ready=1:
  - Stimulus: 8 beats with in_side=0..7, in_d1 row0=side*3.
  - Response: out_valid 1 cycle after each accept, same order, payload bit-exact, in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0, in_valid=1 with beats A,B,C.
  - Response: A in main, B in skid, in_ready=0 after B, C held upstream.
  - Then out_ready=1 -> A, B, C delivered in order with no gap after B.
- Flush:
  - Stimulus: main=A, skid=B, flush=1 while presenting C.
  - Response: next cycle out_valid=0, in_ready=1; A, B, C never appear.
  - A subsequent beat D is delivered 1 cycle after accept.
- Mid-stream reset: rst=0 with main and skid full -> next cycle out_valid=0, in_ready=0, all payload 0.
- With CSA_STALL_CNT_EN, CNT_W=4:
  - 20 cycles of out_valid=1, out_ready=0 -> stall_cnt saturates at 15.
  - Flush leaves stall_cnt=15; reset clears it to 0.
